// File: rtl/inst_fetch_unit_if.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit_if
//   Bundles every handshake and bus signal around the instruction fetch unit:
//   the PC-select channel, the instruction-memory request/response channel, the
//   decode channel and the execute flush.
//
//   Every valid/ready pair follows the same rule: a transfer happens on a rising
//   clk edge where both valid and ready are high. Once valid is raised, the
//   producer holds valid and its payload stable until that edge. The
//   instruction-memory response channel has no ready: the fetch unit always
//   takes a response in the cycle imem_rsp_valid_i is high.
//
//   Modports:
//     master - the fetch unit's view (drives pc_ready_o, imem_req_*, inst_*,
//              fetch_err_o).
//     slave  - the environment's view (PC-select, memory, decode, execute).
// -----------------------------------------------------------------------------
interface inst_fetch_unit_if;
  logic [31:0] pc_i;
  logic        pc_valid_i;
  logic        pc_ready_o;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i;
  logic [31:0] imem_rsp_data_i;
  logic        imem_rsp_err_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic        flush_i;
  logic        fetch_err_o;

  modport master (
    input  pc_i, pc_valid_i, imem_req_ready_i, imem_rsp_valid_i,
           imem_rsp_data_i, imem_rsp_err_i, inst_ready_i, flush_i,
    output pc_ready_o, imem_req_valid_o, imem_req_addr_o, inst_o,
           inst_pc_o, inst_valid_o, fetch_err_o
  );

  modport slave (
    output pc_i, pc_valid_i, imem_req_ready_i, imem_rsp_valid_i,
           imem_rsp_data_i, imem_rsp_err_i, inst_ready_i, flush_i,
    input  pc_ready_o, imem_req_valid_o, imem_req_addr_o, inst_o,
           inst_pc_o, inst_valid_o, fetch_err_o
  );
endinterface

// File: rtl/inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// inst_fetch_unit
//   Single-outstanding instruction fetch stage. Takes a PC from PC-select,
//   issues one instruction-memory request, waits (bounded by TIMEOUT_CYCLES)
//   for the response and holds the instruction plus its PC for decode.
//   A bus error or a timeout delivers NOP_INST with fetch_err_o set. A flush
//   from execute kills the fetch in flight: the outstanding response (or
//   timeout) is then swallowed and nothing reaches decode.
//
//   Ports:
//     clk        - clock
//     rst        - synchronous, active-high reset
//     bus        - inst_fetch_unit_if.master (PC, imem, decode, flush signals)
//     dbg_state  - current FSM state (0 IDLE, 1 REQ, 2 WAIT, 3 OUT)
//
//   Build option:
//     INST_FETCH_ALIGN_CHECK_EN - when defined, a PC with bits [1:0] != 0 is
//     not sent to memory; it goes straight to decode as NOP_INST with
//     fetch_err_o set. When undefined, all PC bits go to memory unchanged.
// -----------------------------------------------------------------------------
module inst_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h8000_0000,
  parameter logic [7:0]  TIMEOUT_CYCLES = 8'd255,  // legal range 1..255
  parameter logic [31:0] NOP_INST       = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst,
  inst_fetch_unit_if.master bus,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        pc_ready_q;
  logic        req_valid_q;
  logic        inst_valid_q;
  logic        err_q;
  logic        drop_q;      // fetch was flushed; swallow its completion
  logic [7:0]  tmo_cnt;
  logic        misaligned;
  logic        wait_done;   // WAIT ends this cycle (response or timeout)

`ifdef INST_FETCH_ALIGN_CHECK_EN
  assign misaligned = (bus.pc_i[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  // The counter holds the number of WAIT cycles already completed, so the
  // cycle in which it equals TIMEOUT_CYCLES-1 is the last permitted one.
  // A response in that same cycle still wins over the timeout.
  assign wait_done = bus.imem_rsp_valid_i || (tmo_cnt >= (TIMEOUT_CYCLES - 8'd1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      addr_q       <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      pc_ready_q   <= 1'b1;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
      err_q        <= 1'b0;
      drop_q       <= 1'b0;
      tmo_cnt      <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          // flush has no effect here; a stray late response is ignored.
          if (bus.pc_valid_i) begin
            pc_ready_q <= 1'b0;
            if (misaligned) begin
              inst_q       <= NOP_INST;
              err_q        <= 1'b1;
              inst_pc_q    <= bus.pc_i;
              inst_valid_q <= 1'b1;
              state        <= S_OUT;
            end else begin
              addr_q      <= bus.pc_i;
              req_valid_q <= 1'b1;
              state       <= S_REQ;
            end
          end
        end

        S_REQ: begin
          // A flushed request is never retracted; it completes and is dropped later.
          if (bus.flush_i) drop_q <= 1'b1;
          if (bus.imem_req_ready_i) begin
            req_valid_q <= 1'b0;
            tmo_cnt     <= 8'd0;
            state       <= S_WAIT;
          end
        end

        S_WAIT: begin
          tmo_cnt <= (tmo_cnt == 8'hFF) ? tmo_cnt : tmo_cnt + 8'd1;
          if (wait_done) begin
            if (drop_q || bus.flush_i) begin
              drop_q     <= 1'b0;
              pc_ready_q <= 1'b1;
              state      <= S_IDLE;
            end else begin
              inst_pc_q    <= addr_q;
              inst_valid_q <= 1'b1;
              state        <= S_OUT;
              if (bus.imem_rsp_valid_i && !bus.imem_rsp_err_i) begin
                inst_q <= bus.imem_rsp_data_i;
                err_q  <= 1'b0;
              end else begin
                inst_q <= NOP_INST;
                err_q  <= 1'b1;
              end
            end
          end else if (bus.flush_i) begin
            drop_q <= 1'b1;
          end
        end

        S_OUT: begin
          if (bus.flush_i || bus.inst_ready_i) begin
            inst_valid_q <= 1'b0;
            err_q        <= 1'b0;
            pc_ready_q   <= 1'b1;
            state        <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.pc_ready_o       = pc_ready_q;
  assign bus.imem_req_valid_o = req_valid_q;
  assign bus.imem_req_addr_o  = addr_q;
  assign bus.inst_o           = inst_q;
  assign bus.inst_pc_o        = inst_pc_q;
  assign bus.inst_valid_o     = inst_valid_q;
  assign bus.fetch_err_o      = err_q;
  assign dbg_state            = state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_inst_fetch_unit
//   Drives inst_fetch_unit through a table of fetch scenarios, hand-written
//   corner sequences (reset mid-OUT, flush in OUT, late response in IDLE,
//   misaligned PC) and randomized fetches. Expected deliveries come from a
//   transaction-level model of the fetch rules and are queued in exp_q.
// -----------------------------------------------------------------------------
module tb_inst_fetch_unit;

  localparam logic [7:0]  TMO      = 8'd8;
  localparam logic [31:0] RST_PC   = 32'h8000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;

  inst_fetch_unit_if bus ();

  inst_fetch_unit #(
    .RESET_PC      (RST_PC),
    .TIMEOUT_CYCLES(TMO),
    .NOP_INST      (NOP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [64:0] exp_q[$];  // {fetch_err, inst_pc, inst}

  typedef struct {
    logic [31:0] pc;
    int          rd;        // cycles imem_req_ready_i stays low
    int          d;         // response in WAIT cycle d; d > TMO means never
    logic [31:0] data;
    logic        err;
    logic        flush_req; // flush during the request handshake cycle
    int          f;         // flush in WAIT cycle f (0 = none)
    int          bp;        // decode backpressure cycles in OUT
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic        exp_err;
  } vec_t;

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_drive();
    bus.pc_valid_i       = 1'b0;
    bus.pc_i             = 32'h0;
    bus.imem_req_ready_i = 1'b0;
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_data_i  = 32'h0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.inst_ready_i     = 1'b0;
    bus.flush_i          = 1'b0;
  endtask

  // Reference model: what decode should see for one fetch scenario.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    r.exp_valid = !(v.flush_req || v.f != 0);
    if (v.d > int'(TMO) || v.err) begin
      r.exp_inst = NOP;
      r.exp_err  = 1'b1;
    end else begin
      r.exp_inst = v.data;
      r.exp_err  = 1'b0;
    end
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    chk({tag, "_pc_ready"},  65'(bus.pc_ready_o), 65'd1);
    chk({tag, "_req_valid"}, 65'(bus.imem_req_valid_o), 65'd0);
    chk({tag, "_req_addr"},  65'(bus.imem_req_addr_o), 65'(RST_PC));
    chk({tag, "_inst_valid"},65'(bus.inst_valid_o), 65'd0);
    chk({tag, "_fetch_err"}, 65'(bus.fetch_err_o), 65'd0);
    chk({tag, "_inst"},      65'(bus.inst_o), 65'(NOP));
    chk({tag, "_inst_pc"},   65'(bus.inst_pc_o), 65'(RST_PC));
  endtask

  // One complete fetch. Called and returning on a negedge. With accept=0
  // it returns with the instruction still held in OUT.
  task automatic do_fetch(input vec_t v, input bit accept);
    int kend;
    logic [64:0] exp;
    kend = (v.d <= int'(TMO)) ? v.d : int'(TMO);
    if (v.exp_valid) exp_q.push_back({v.exp_err, v.pc, v.exp_inst});

    chk("idle_pc_ready", 65'(bus.pc_ready_o), 65'd1);
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = v.pc;
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    bus.pc_i       = $urandom;
    for (int i = 0; i < v.rd; i++) begin
      chk("req_valid_stall", 65'(bus.imem_req_valid_o), 65'd1);
      chk("req_addr_stall",  65'(bus.imem_req_addr_o), 65'(v.pc));
      chk("req_pc_ready",    65'(bus.pc_ready_o), 65'd0);
      @(negedge clk);
    end
    chk("req_valid", 65'(bus.imem_req_valid_o), 65'd1);
    chk("req_addr",  65'(bus.imem_req_addr_o), 65'(v.pc));
    bus.imem_req_ready_i = 1'b1;
    bus.flush_i          = v.flush_req;
    @(negedge clk);
    bus.imem_req_ready_i = 1'b0;
    bus.flush_i          = 1'b0;
    chk("req_dropped", 65'(bus.imem_req_valid_o), 65'd0);

    for (int k = 1; k <= kend; k++) begin
      bus.imem_rsp_valid_i = (k == v.d);
      bus.imem_rsp_data_i  = (k == v.d) ? v.data : $urandom;
      bus.imem_rsp_err_i   = (k == v.d) && v.err;
      bus.flush_i          = (k == v.f);
      chk("wait_inst_valid", 65'(bus.inst_valid_o), 65'd0);
      @(negedge clk);
    end
    bus.imem_rsp_valid_i = 1'b0;
    bus.imem_rsp_err_i   = 1'b0;
    bus.flush_i          = 1'b0;

    chk("inst_valid", 65'(bus.inst_valid_o), 65'(v.exp_valid));
    if (!v.exp_valid) begin
      chk("drop_pc_ready", 65'(bus.pc_ready_o), 65'd1);
      return;
    end
    exp = exp_q.pop_front();
    chk("deliver", {bus.fetch_err_o, bus.inst_pc_o, bus.inst_o}, exp);
    for (int j = 0; j < v.bp; j++) begin
      @(negedge clk);
      chk("bp_hold", {bus.fetch_err_o, bus.inst_pc_o, bus.inst_o}, exp);
      chk("bp_valid", 65'(bus.inst_valid_o), 65'd1);
      chk("bp_pc_ready", 65'(bus.pc_ready_o), 65'd0);
    end
    if (!accept) return;
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    chk("after_accept_valid", 65'(bus.inst_valid_o), 65'd0);
    chk("after_accept_pc_ready", 65'(bus.pc_ready_o), 65'd1);
  endtask

  vec_t tbl[8];
  vec_t v;

  initial begin
    // pc, rd, d, data, err, flush_req, f, bp, exp_valid, exp_inst, exp_err
    tbl[0] = '{32'h8000_0000, 0, 1, 32'h0050_0093, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0050_0093, 1'b0};
    tbl[1] = '{32'h8000_0004, 4, 1, 32'h00a0_0113, 1'b0, 1'b0, 0, 0, 1'b1, 32'h00a0_0113, 1'b0};
    tbl[2] = '{32'h8000_0008, 0, 9, 32'h1111_1111, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0000_0013, 1'b1};
    tbl[3] = '{32'h8000_000C, 0, 3, 32'hDEAD_BEEF, 1'b0, 1'b0, 2, 0, 1'b0, 32'h0,         1'b0};
    tbl[4] = '{32'h8000_0100, 1, 2, 32'h0000_0517, 1'b0, 1'b0, 0, 5, 1'b1, 32'h0000_0517, 1'b0};
    tbl[5] = '{32'h8000_0010, 0, 2, 32'h1234_5678, 1'b1, 1'b0, 0, 1, 1'b1, 32'h0000_0013, 1'b1};
    tbl[6] = '{32'h8000_0014, 2, 8, 32'h0BAD_F00D, 1'b0, 1'b0, 0, 0, 1'b1, 32'h0BAD_F00D, 1'b0};
    tbl[7] = '{32'h8000_0018, 0, 4, 32'hCAFE_0001, 1'b0, 1'b1, 0, 0, 1'b0, 32'h0,         1'b0};

    idle_drive();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_state("post_reset");

    for (int i = 0; i < 8; i++) do_fetch(tbl[i], 1'b1);

    // Late response arriving in IDLE must be ignored.
    bus.imem_rsp_valid_i = 1'b1;
    bus.imem_rsp_data_i  = 32'h5555_AAAA;
    @(negedge clk);
    bus.imem_rsp_valid_i = 1'b0;
    chk("late_rsp_valid", 65'(bus.inst_valid_o), 65'd0);
    chk("late_rsp_pc_ready", 65'(bus.pc_ready_o), 65'd1);

    // Flush while holding in OUT.
    v = model('{32'h8000_0200, 0, 1, 32'h0000_0093, 1'b0, 1'b0, 0, 2, 1'b0, 32'h0, 1'b0});
    do_fetch(v, 1'b0);
    bus.flush_i = 1'b1;
    @(negedge clk);
    bus.flush_i = 1'b0;
    chk("flush_out_valid", 65'(bus.inst_valid_o), 65'd0);
    chk("flush_out_pc_ready", 65'(bus.pc_ready_o), 65'd1);

    // Flush and accept together in OUT.
    v = model('{32'h8000_0204, 0, 1, 32'h0000_0113, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0});
    do_fetch(v, 1'b0);
    bus.flush_i      = 1'b1;
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    bus.flush_i      = 1'b0;
    bus.inst_ready_i = 1'b0;
    chk("flush_accept_valid", 65'(bus.inst_valid_o), 65'd0);

    // Reset pulsed in OUT under backpressure.
    v = model('{32'h8000_0300, 0, 2, 32'h0030_0193, 1'b0, 1'b0, 0, 2, 1'b0, 32'h0, 1'b0});
    do_fetch(v, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_reset_state("rst_mid_out");

    // Misaligned PC.
`ifdef INST_FETCH_ALIGN_CHECK_EN
    bus.pc_valid_i = 1'b1;
    bus.pc_i       = 32'h8000_0002;
    @(negedge clk);
    bus.pc_valid_i = 1'b0;
    chk("mis_req_valid", 65'(bus.imem_req_valid_o), 65'd0);
    chk("mis_deliver", {bus.inst_valid_o, bus.fetch_err_o, bus.inst_pc_o, bus.inst_o},
        {1'b1, 1'b1, 32'h8000_0002, NOP});
    bus.inst_ready_i = 1'b1;
    @(negedge clk);
    bus.inst_ready_i = 1'b0;
    chk("mis_after_valid", 65'(bus.inst_valid_o), 65'd0);
`else
    v = model('{32'h8000_0002, 0, 1, 32'h0040_0213, 1'b0, 1'b0, 0, 0, 1'b0, 32'h0, 1'b0});
    do_fetch(v, 1'b1);
`endif

    // Randomized fetches against the reference model.
    for (int n = 0; n < 40; n++) begin
      int kend;
      v.pc        = $urandom & 32'hFFFF_FFFC;
      v.rd        = $urandom_range(0, 3);
      v.d         = $urandom_range(1, 11);
      v.data      = $urandom;
      v.err       = ($urandom_range(0, 3) == 0);
      v.flush_req = ($urandom_range(0, 9) == 0);
      kend        = (v.d <= int'(TMO)) ? v.d : int'(TMO);
      v.f         = ($urandom_range(0, 4) == 0) ? $urandom_range(1, kend) : 0;
      v.bp        = $urandom_range(0, 3);
      v = model(v);
      do_fetch(v, 1'b1);
    end

    chk("exp_q_empty", 65'(exp_q.size()), 65'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch stage directly downstream of the PC-select stage.
- Accepts the next PC and issues one request to instruction memory over a valid/ready request channel, then waits for the response, which may arrive after a variable number of cycles.
- Holds the fetched instruction and its PC for decode until decode accepts it.
- Supports flush from execute on redirect, and a response timeout that returns an error.

Parameters:
- RESET_PC, 32'h80000000, value driven on inst_pc_o after reset.
- TIMEOUT_CYCLES, 255, maximum number of cycles in WAIT before the fetch is aborted with an error; width 8 bits, legal range 1..255.
- NOP_INST, 32'h00000013, instruction delivered on error (addi x0,x0,0).

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- pc_i  in  32  next PC from PC-select.
- pc_valid_i  in  1  pc_i valid.
- pc_ready_o  out  1  fetch accepts pc_i this cycle.
- imem_req_valid_o  out  1  memory request valid.
- imem_req_ready_i  in  1  memory accepts request.
- imem_req_addr_o  out  32  request address.
- imem_rsp_valid_i  in  1  response valid; one response per accepted request.
- imem_rsp_data_i  in  32  response instruction.
- imem_rsp_err_i  in  1  response bus error.
- inst_o  out  32  instruction to decode.
- inst_pc_o  out  32  PC of inst_o.
- inst_valid_o  out  1  inst_o/inst_pc_o valid.
- inst_ready_i  in  1  decode accepts instruction.
- flush_i  in  1  execute redirect; kill the in-flight fetch.
- fetch_err_o  out  1  error flag qualified by inst_valid_o.

Behaviour:
- States:
  - IDLE: pc_ready_o=1. On pc_valid_i, latch pc_i into the address register and go to REQ.
  - REQ: imem_req_valid_o=1 and imem_req_addr_o=latched PC. On imem_req_ready_i, go to WAIT and clear the timeout counter.
  - WAIT: the timeout counter increments each cycle.
    - On imem_rsp_valid_i: capture data and error, then go to OUT.
    - If the counter reaches TIMEOUT_CYCLES first: inst_o=NOP_INST, fetch_err_o=1, go to OUT.
  - OUT: inst_valid_o=1, outputs held stable. On inst_ready_i, go to IDLE.
- Latency: response in the same cycle it is captured, next cycle inst_valid_o=1.
- Minimum path: pc accepted in cycle N, request in N+1, response in N+2, inst_valid_o in N+3.
- Throughput: one instruction in flight at a time; no pipelining.
- imem_req_valid_o stays asserted with a stable address until accepted; it is never dropped mid-handshake.
- Response error: inst_o=NOP_INST, fetch_err_o=1, inst_pc_o=faulting PC.
- flush_i, handled per state:
  - IDLE: no effect.
  - REQ: request still completes its handshake (no retraction); set the drop flag.
  - WAIT: set the drop flag.
  - OUT: go straight to IDLE with inst_valid_o=0 the next cycle.
- Drop flag set: the response (or timeout) is consumed silently, inst_valid_o stays 0, and the FSM returns to IDLE. The drop flag clears on entry to IDLE.
- flush_i and imem_rsp_valid_i in the same cycle: the response is dropped.
- flush_i and inst_ready_i in the same cycle in OUT: go to IDLE (same result either way).
- pc_ready_o is 0 in every state except IDLE; pc_i is ignored while not ready.
- Reset values:
  - FSM=IDLE.
  - inst_valid_o=0, imem_req_valid_o=0, fetch_err_o=0.
  - inst_o=NOP_INST.
  - inst_pc_o=RESET_PC, imem_req_addr_o=RESET_PC.
  - Timeout counter=0, drop flag=0.
- Reset mid-operation: all state is abandoned immediately. A late memory response arriving in IDLE is ignored; the memory side is reset together with this block.
- Counter: 8-bit and saturating; it never wraps.

Optional Feature:
- Macro: INST_FETCH_ALIGN_CHECK_EN.
- Defined: in IDLE, a pc_i with pc_i[1:0]!=0 is not sent to memory. The FSM goes straight to OUT with inst_o=NOP_INST, fetch_err_o=1 and inst_pc_o=pc_i. flush_i behaves as for OUT.
- Not defined: bits [1:0] are passed through unchanged on imem_req_addr_o, and no alignment error is ever raised.

Test Plan:
- Reset, then pc_i=0x80000000 with zero-wait memory returning 0x00500093 and inst_ready_i=1: inst_valid_o high 3 cycles after acceptance, inst_o=0x00500093, inst_pc_o=0x80000000, fetch_err_o=0.
- imem_req_ready_i held low 4 cycles on pc 0x80000004: imem_req_valid_o and address 0x80000004 stay stable all 4 cycles; normal delivery after the handshake.
- Response never arrives, TIMEOUT_CYCLES=8: inst_valid_o=1 with inst_o=0x00000013 and fetch_err_o=1 after 8 WAIT cycles.
- flush_i pulsed in WAIT, then response 0xDEADBEEF arrives: no inst_valid_o; next pc 0x80000100 fetched normally afterwards.
- Decode backpressure (inst_ready_i=0 for 5 cycles) in OUT: outputs stable and pc_ready_o=0 throughout; rst pulsed mid-OUT gives inst_valid_o=0 and inst_pc_o=0x80000000 the next cycle.
- With INST_FETCH_ALIGN_CHECK_EN defined, pc_i=0x80000002: no imem request, fetch_err_o=1, inst_pc_o=0x80000002. Without the macro, the request goes out to 0x80000002.
